sbox1_arbiter: RTL and testbench

SBOX1_ARBITER -- requirements
Module: sbox1_arbiter

---
 rtl/sbox1_arbiter.sv | 116 +++++++++++
 tb/tb_sbox1_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox1_arbiter.sv
// Round-robin arbiter sharing one 5-to-2 sbox1 lookup between NREQ requesters.
// Two-stage pipeline: S1 holds the accepted operand, S2 holds the registered result.
module sbox1 (
  input  logic [4:0] x,
  output logic [1:0] y
);
  always_comb begin
    y = 2'h0;
    case (x)
      5'h00: y = 2'h2;  5'h01: y = 2'h0;  5'h02: y = 2'h1;  5'h03: y = 2'h1;
      5'h04: y = 2'h2;  5'h05: y = 2'h3;  5'h06: y = 2'h3;  5'h07: y = 2'h0;
      5'h08: y = 2'h3;  5'h09: y = 2'h2;  5'h0a: y = 2'h2;  5'h0b: y = 2'h0;
      5'h0c: y = 2'h1;  5'h0d: y = 2'h1;  5'h0e: y = 2'h0;  5'h0f: y = 2'h3;
      5'h10: y = 2'h0;  5'h11: y = 2'h3;  5'h12: y = 2'h3;  5'h13: y = 2'h0;
      5'h14: y = 2'h2;  5'h15: y = 2'h2;  5'h16: y = 2'h1;  5'h17: y = 2'h1;
      5'h18: y = 2'h2;  5'h19: y = 2'h2;  5'h1a: y = 2'h0;  5'h1b: y = 2'h3;
      5'h1c: y = 2'h1;  5'h1d: y = 2'h1;  5'h1e: y = 2'h3;  5'h1f: y = 2'h0;
      default: y = 2'h0;
    endcase
  end
endmodule

module sbox1_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [1:0]        rsp_data,
  output logic [2:0]        rsp_id,
  output logic              busy,
  output logic [15:0]       count
);
  logic [2:0]      ptr;
  logic [2:0]      next_ptr;
  logic [NREQ-1:0] pick;
  logic [2:0]      gnt_idx;
  logic [4:0]      sel_data;
  logic            found;
  logic            accept;
  int              idx;

  logic            s1_valid;
  logic [4:0]      s1_data;
  logic [2:0]      s1_id;
  logic [NREQ-1:0] s1_onehot;
  logic [1:0]      sbox_y;

  // First valid requester at or after ptr, wrapping; only one can be picked.
  always_comb begin
    pick     = '0;
    gnt_idx  = 3'd0;
    sel_data = 5'd0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        gnt_idx   = 3'(idx);
        sel_data  = req_data[5*idx +: 5];
      end
    end
  end

  assign req_ready = (en && !rst) ? pick : '0;
  assign accept    = |req_ready;
  assign next_ptr  = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

  always_comb begin
    s1_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      s1_onehot[i] = (s1_id == 3'(i));
    end
  end

  sbox1 u_sbox1 (
    .x (s1_data),
    .y (sbox_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 3'd0;
      s1_valid  <= 1'b0;
      s1_data   <= 5'd0;
      s1_id     <= 3'd0;
      rsp_valid <= '0;
      rsp_data  <= 2'd0;
      rsp_id    <= 3'd0;
      count     <= 16'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= sel_data;
        s1_id   <= gnt_idx;
        ptr     <= next_ptr;
      end
      rsp_valid <= s1_valid ? s1_onehot : '0;
      // count tracks the pulse launched at this same edge, so it is current during the pulse
      if (s1_valid) begin
        rsp_data <= sbox_y;
        rsp_id   <= s1_id;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

  assign busy = s1_valid | (|rsp_valid);

endmodule

// File: tb/tb_sbox1_arbiter.sv
// Randomized and directed bench for sbox1_arbiter against a queue-based reference model.
module tb_sbox1_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [1:0]        rsp_data;
  logic [2:0]        rsp_id;
  logic              busy;
  logic [15:0]       count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sbox1_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .count     (count)
  );

  int sbox_tbl [32] = '{2,0,1,1,2,3,3,0,3,2,2,0,1,1,0,3,0,3,3,0,2,2,1,1,2,2,0,3,1,1,3,0};

  // Reference model: pending lookups are a queue tagged with the edge on which they appear.
  typedef struct {int id; int data; int due;} item_t;
  item_t           q[$];
  int              m_ptr   = 0;
  int              m_gnt   = -1;
  int              edge_no = 0;
  int              m_count = 0;
  logic [NREQ-1:0] m_ready = '0;
  logic [NREQ-1:0] m_rv    = '0;
  logic [1:0]      m_rd    = '0;
  logic [2:0]      m_rid   = '0;
  logic            m_busy  = 1'b0;
  logic [29:0]     obs, exp_v;

  task automatic model_edge();
    item_t it;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      q.delete();
      m_rv = '0; m_rd = '0; m_rid = '0; m_count = 0; m_ptr = 0;
    end else begin
      m_rv = '0;
      if (q.size() > 0 && q[0].due == edge_no) begin
        it      = q.pop_front();
        m_rv    = NREQ'(1) << it.id;
        m_rd    = 2'(sbox_tbl[it.data]);
        m_rid   = 3'(it.id);
        if (m_count < 65535) m_count++;
      end
      if (m_gnt >= 0) begin
        it.id   = m_gnt;
        it.data = int'((req_data >> (5 * m_gnt)) & 20'h1f);
        it.due  = edge_no + 1;
        q.push_back(it);
        m_ptr = (m_gnt + 1) % NREQ;
      end
    end
  endtask

  // Completes the current cycle, then applies new inputs and computes expectations.
  task automatic drive(input logic r, input logic e, input logic [NREQ-1:0] v,
                       input logic [5*NREQ-1:0] d);
    model_edge();
    @(negedge clk);
    rst = r; en = e; req_valid = v; req_data = d;
    #1;
    m_gnt = -1;
    if (!r && e) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_gnt < 0 && v[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
      end
    end
    m_ready = (m_gnt >= 0) ? (NREQ'(1) << m_gnt) : '0;
    m_busy  = (q.size() > 0) || (m_rv != '0);
    obs     = {req_ready, rsp_valid, rsp_data, rsp_id, busy, count};
    exp_v   = {m_ready, m_rv, m_rd, m_rid, m_busy, 16'(m_count)};
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, '1, '1);
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    drive(1'b0, 1'b0, '0, '0);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, busy, count} !== 26'd0) begin
      failures++;
      $display("FAIL reset_state rv=%b rd=%h id=%h busy=%b count=%h exp all zero",
               rsp_valid, rsp_data, rsp_id, busy, count);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b0, 1'b1, 4'b0001, 20'h00005);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, '0, '0);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL single_cycle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
      if (c == 1) begin
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, count} !== {4'b0001, 2'h3, 3'd0, 16'd1}) begin
          failures++;
          $display("FAIL single_rsp rv=%b rd=%h id=%0d count=%0d exp rv=0001 rd=3 id=0 count=1",
                   rsp_valid, rsp_data, rsp_id, count);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_rsp [4] = '{2, 3, 3, 0};
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 1'b1, '1, {5'h1f, 5'h1b, 5'h08, 5'h00});
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rr_cycle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
      checks++;
      if (req_ready !== (NREQ'(1) << (c % 4))) begin
        failures++; $display("FAIL rr_grant c=%0d got=%b exp_idx=%0d", c, req_ready, c % 4);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== (NREQ'(1) << ((c - 2) % 4)) || rsp_data !== 2'(exp_rsp[(c - 2) % 4])) begin
          failures++;
          $display("FAIL rr_rsp c=%0d rv=%b rd=%0d exp_rd=%0d", c, rsp_valid, rsp_data,
                   exp_rsp[(c - 2) % 4]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int seen [$];
    do_reset();
    for (int c = 0; c < 34; c++) begin
      if (c < 32) drive(1'b0, 1'b1, 4'b0100, 20'(c) << 10);
      else        drive(1'b0, 1'b1, '0, '0);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL sweep_cycle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
      if (rsp_valid != '0) begin
        seen.push_back(int'(rsp_data));
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_id !== 3'd2) begin
          failures++; $display("FAIL sweep_id rv=%b id=%0d exp rv=0100 id=2", rsp_valid, rsp_id);
        end
      end
    end
    checks++;
    if (seen.size() != 32 || count !== 16'd32) begin
      failures++; $display("FAIL sweep_total got_rsp=%0d count=%0d exp 32", seen.size(), count);
    end
    for (int i = 0; i < seen.size() && i < 32; i++) begin
      checks++;
      if (seen[i] != sbox_tbl[i]) begin
        failures++; $display("FAIL sweep_data x=%0d got=%0d exp=%0d", i, seen[i], sbox_tbl[i]);
      end
    end
  endtask

  task automatic test_enable();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, '1, 20'h5a5a5);
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || obs !== exp_v) begin
        failures++; $display("FAIL en_block c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    drive(1'b0, 1'b1, 4'b0010, 20'h000e0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, '1, 20'h000e0);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL en_drain c=%0d got=%h exp=%h", c, obs, exp_v);
      end
      if (rsp_valid != '0) pulses++;
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0 || count !== 16'd1) begin
      failures++;
      $display("FAIL en_complete pulses=%0d busy=%b count=%0d exp 1/0/1", pulses, busy, count);
    end
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    do_reset();
    drive(1'b0, 1'b1, 4'b1000, 20'h0f << 15);
    drive(1'b1, 1'b1, '1, '1);
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, '0, '0);
      if (rsp_valid != '0) pulses++;
    end
    checks++;
    if (pulses != 0 || count !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_drop pulses=%0d count=%0d busy=%b exp 0/0/0", pulses, count, busy);
    end
    drive(1'b0, 1'b1, '1, '0);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL mid_rst_grant got=%b exp=0001", req_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
            NREQ'($urandom), 20'($urandom));
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 65545; c++) begin
      drive(1'b0, 1'b1, '1, 20'($urandom));
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL sat_cycle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (count !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold got=%h exp=ffff", count);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_sweep();
    test_enable();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
